// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Control outputs are bundled in one packed struct so each state maps to a single constant.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } state_t;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [31:0] NOP      = 32'h0;

  typedef struct packed {
    logic pc_write;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic pipe_freeze;
    logic halted;
  } ctrl_t;

  // Bit order: pc_write, if_id_stall, if_id_flush, id_ex_flush, pipe_freeze, halted
  localparam ctrl_t CTRL_IDLE     = 6'b001100;
  localparam ctrl_t CTRL_RUN      = 6'b100000;
  localparam ctrl_t CTRL_BRANCH   = 6'b101000;
  localparam ctrl_t CTRL_LOAD_USE = 6'b010100;
  localparam ctrl_t CTRL_FREEZE   = 6'b010010;
  localparam ctrl_t CTRL_HALT     = 6'b010011;

  function automatic logic load_use_hazard(
    input logic       memread,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2
  );
    return memread && (rd != REG_ZERO) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stall/flush/freeze
// generation, memory-miss wait with timeout halt, and saturating perf counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             pipe_freeze_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output state_t           dbg_state_o
);

  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  state_t     r_state;
  logic [7:0] r_wait;
  ctrl_t      w_ctrl;
  logic       w_miss;
  logic       w_load_use;
  logic       w_stall_inc;
  logic       w_flush_inc;

  assign w_miss     = mem_req_i && !mem_ack_i;
  assign w_load_use = load_use_hazard(ex_memread_i, ex_rd_i, id_rs1_i, id_rs2_i);

  // Controls are Mealy in RUN so hazards are resolved in the cycle they appear.
  always_comb begin
    w_ctrl = CTRL_IDLE;
    case (r_state)
      IDLE:     w_ctrl = CTRL_IDLE;
      RUN: begin
        if (w_miss)              w_ctrl = CTRL_FREEZE;
        else if (w_load_use)     w_ctrl = CTRL_LOAD_USE;
        else if (branch_taken_i) w_ctrl = CTRL_BRANCH;
        else                     w_ctrl = CTRL_RUN;
      end
      MEM_WAIT: w_ctrl = CTRL_FREEZE;
      HALT:     w_ctrl = CTRL_HALT;
      default:  w_ctrl = CTRL_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_wait  <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) r_state <= RUN;
        end
        RUN: begin
          if (w_miss) begin
            r_state <= MEM_WAIT;
            r_wait  <= 8'd0;
          end
        end
        MEM_WAIT: begin
          // An ack in the final allowed wait cycle still wins over the timeout.
          if (mem_ack_i) begin
            r_state <= RUN;
          end else begin
            r_wait <= r_wait + 8'd1;
            if ((r_wait + 8'd1) == TIMEOUT_W) r_state <= HALT;
          end
        end
        HALT:    r_state <= HALT;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_stall_inc = ((r_state == RUN) || (r_state == MEM_WAIT)) && !w_ctrl.pc_write;
  assign w_flush_inc = (r_state == RUN) && w_ctrl.if_id_flush;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_stall_inc),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_flush_inc),
    .cnt_o (flush_cnt_o)
  );

  assign pc_write_o    = w_ctrl.pc_write;
  assign if_id_stall_o = w_ctrl.if_id_stall;
  assign if_id_flush_o = w_ctrl.if_id_flush;
  assign id_ex_flush_o = w_ctrl.id_ex_flush;
  assign pipe_freeze_o = w_ctrl.pipe_freeze;
  assign halted_o      = w_ctrl.halted;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table, multi-cycle corner sequences
// on a small TIMEOUT/CNT_W instance, and randomized traffic against a reference model.
module tb_pipeline_hazard_ctrl;
  import hazard_pkg::*;

  typedef struct packed {
    logic       rst;
    logic       start;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       memread;
    logic [4:0] rd;
    logic       br;
    logic       req;
    logic       ack;
  } in_t;

  typedef struct {
    in_t        x;
    logic [5:0] o;
    int         sc;
    int         fc;
  } vec_t;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_WAIT = 2;
  localparam int M_HALT = 3;

  typedef struct {
    int mode;
    int waited;
    int stall;
    int flush;
  } mdl_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t in_a, in_b, rst_v;
  int  total = 0;
  int  bad   = 0;

  logic        pc_a, stl_a, fif_a, fex_a, frz_a, hlt_a;
  logic [15:0] sc_a, fc_a;
  state_t      st_a;
  logic        pc_b, stl_b, fif_b, fex_b, frz_b, hlt_b;
  logic [3:0]  sc_b, fc_b;
  state_t      st_b;
  logic [5:0]  o_a, o_b;

  assign o_a = {pc_a, stl_a, fif_a, fex_a, frz_a, hlt_a};
  assign o_b = {pc_b, stl_b, fif_b, fex_b, frz_b, hlt_b};

  pipeline_hazard_ctrl #(.TIMEOUT(64), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(in_a.rst), .start_i(in_a.start),
    .id_rs1_i(in_a.rs1), .id_rs2_i(in_a.rs2), .ex_memread_i(in_a.memread),
    .ex_rd_i(in_a.rd), .branch_taken_i(in_a.br), .mem_req_i(in_a.req),
    .mem_ack_i(in_a.ack), .pc_write_o(pc_a), .if_id_stall_o(stl_a),
    .if_id_flush_o(fif_a), .id_ex_flush_o(fex_a), .pipe_freeze_o(frz_a),
    .halted_o(hlt_a), .stall_cnt_o(sc_a), .flush_cnt_o(fc_a), .dbg_state_o(st_a)
  );

  pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut_b (
    .clk_i(clk), .rst_i(in_b.rst), .start_i(in_b.start),
    .id_rs1_i(in_b.rs1), .id_rs2_i(in_b.rs2), .ex_memread_i(in_b.memread),
    .ex_rd_i(in_b.rd), .branch_taken_i(in_b.br), .mem_req_i(in_b.req),
    .mem_ack_i(in_b.ack), .pc_write_o(pc_b), .if_id_stall_o(stl_b),
    .if_id_flush_o(fif_b), .id_ex_flush_o(fex_b), .pipe_freeze_o(frz_b),
    .halted_o(hlt_b), .stall_cnt_o(sc_b), .flush_cnt_o(fc_b), .dbg_state_o(st_b)
  );

  // ---------------- reference model ----------------
  function automatic logic [5:0] mdl_out(int mode, in_t x);
    logic hazard;
    hazard = x.memread && (x.rd != 5'd0) && ((x.rd == x.rs1) || (x.rd == x.rs2));
    if (mode == M_IDLE) return 6'b001100;
    if (mode == M_HALT) return 6'b010011;
    if (mode == M_WAIT) return 6'b010010;
    if (x.req && !x.ack) return 6'b010010;
    if (hazard)          return 6'b010100;
    if (x.br)            return 6'b101000;
    return 6'b100000;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, in_t x, int timeout, int cmax);
    mdl_t       n;
    logic [5:0] o;
    n = m;
    o = mdl_out(m.mode, x);
    if (!x.rst) begin
      n.mode = M_IDLE; n.waited = 0; n.stall = 0; n.flush = 0;
      return n;
    end
    if ((m.mode == M_RUN || m.mode == M_WAIT) && !o[5] && m.stall < cmax) n.stall = m.stall + 1;
    if (m.mode == M_RUN && o[3] && m.flush < cmax) n.flush = m.flush + 1;
    case (m.mode)
      M_IDLE: if (x.start) n.mode = M_RUN;
      M_RUN:  if (x.req && !x.ack) begin n.mode = M_WAIT; n.waited = 0; end
      M_WAIT: begin
        if (x.ack) n.mode = M_RUN;
        else begin
          n.waited = m.waited + 1;
          if (n.waited >= timeout) n.mode = M_HALT;
        end
      end
      default: n.mode = m.mode;
    endcase
    return n;
  endfunction

  mdl_t mdl_a = '{M_IDLE, 0, 0, 0};
  mdl_t mdl_b = '{M_IDLE, 0, 0, 0};

  always @(posedge clk) begin
    mdl_a = mdl_step(mdl_a, in_a, 64, 65535);
    mdl_b = mdl_step(mdl_b, in_b, 4, 15);
  end

  function automatic int mode_state(int mode);
    case (mode)
      M_RUN:   return int'(RUN);
      M_WAIT:  return int'(MEM_WAIT);
      M_HALT:  return int'(HALT);
      default: return int'(IDLE);
    endcase
  endfunction

  // ---------------- driver / scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input in_t a, input in_t b);
    @(negedge clk);
    in_a = a;
    in_b = b;
    #1;
  endtask

  function automatic in_t mk(logic start, logic [4:0] rs1, logic [4:0] rs2, logic memread,
                             logic [4:0] rd, logic br, logic req, logic ack);
    in_t x;
    x.rst = 1'b1; x.start = start; x.rs1 = rs1; x.rs2 = rs2; x.memread = memread;
    x.rd = rd; x.br = br; x.req = req; x.ack = ack;
    return x;
  endfunction

  task automatic b_to_run();
    drive(rst_v, rst_v);
    drive(rst_v, mk(1, 0, 0, 0, 0, 0, 0, 0));
    chk("b_idle_out", int'(o_b), 6'b001100);
  endtask

  task automatic b_miss_check(input string tag);
    drive(rst_v, mk(0, 0, 0, 0, 0, 0, 1, 0));
    chk({tag, "_req"}, int'(o_b), 6'b010010);
    for (int k = 1; k <= 4; k++) begin
      drive(rst_v, mk(0, 0, 0, 0, 0, 0, 1, 0));
      chk({tag, "_wait"}, int'(o_b), 6'b010010);
    end
    drive(rst_v, mk(0, 0, 0, 0, 0, 0, 0, 0));
    chk({tag, "_halt"}, int'(o_b), 6'b010011);
  endtask

  vec_t tbl[19];

  initial begin
    in_t x;
    rst_v = '0;
    in_a  = '0;
    in_b  = '0;

    // Directed table on dut_a; order {start, rs1, rs2, memread, rd, br, req, ack}.
    tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0),   6'b001100, 0, 0};
    tbl[1]  = '{mk(0, 0, 0, 0, 0, 1, 1, 0),   6'b001100, 0, 0};
    tbl[2]  = '{mk(1, 0, 0, 0, 0, 0, 0, 0),   6'b001100, 0, 0};
    tbl[3]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0),   6'b100000, 0, 0};
    tbl[4]  = '{mk(0, 0, 5, 1, 5, 1, 0, 0),   6'b010100, 0, 0};
    tbl[5]  = '{mk(0, 0, 0, 1, 0, 0, 0, 0),   6'b100000, 1, 0};
    tbl[6]  = '{mk(0, 0, 0, 0, 0, 1, 0, 0),   6'b101000, 1, 0};
    tbl[7]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0),   6'b100000, 1, 1};
    tbl[8]  = '{mk(0, 0, 0, 0, 0, 0, 1, 1),   6'b100000, 1, 1};
    tbl[9]  = '{mk(0, 0, 0, 0, 0, 0, 1, 0),   6'b010010, 1, 1};
    tbl[10] = '{mk(0, 3, 3, 1, 3, 1, 1, 0),   6'b010010, 2, 1};
    tbl[11] = '{mk(0, 0, 0, 0, 0, 0, 1, 0),   6'b010010, 3, 1};
    tbl[12] = '{mk(0, 0, 0, 0, 0, 0, 0, 1),   6'b010010, 4, 1};
    tbl[13] = '{mk(0, 0, 0, 0, 0, 0, 0, 0),   6'b100000, 5, 1};
    tbl[14] = '{mk(0, 7, 0, 1, 7, 1, 1, 0),   6'b010010, 5, 1};
    tbl[15] = '{mk(0, 0, 0, 0, 0, 0, 0, 1),   6'b010010, 6, 1};
    tbl[16] = '{mk(0, 31, 0, 1, 31, 0, 0, 0), 6'b010100, 7, 1};
    tbl[17] = '{mk(0, 31, 31, 0, 31, 1, 0, 0), 6'b101000, 8, 1};
    tbl[18] = '{mk(1, 0, 0, 0, 0, 0, 0, 0),   6'b100000, 8, 2};

    drive(rst_v, rst_v);
    drive(rst_v, rst_v);
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].x, rst_v);
      chk($sformatf("tbl%0d_ctrl", i), int'(o_a), int'(tbl[i].o));
      chk($sformatf("tbl%0d_stall_cnt", i), int'(sc_a), tbl[i].sc);
      chk($sformatf("tbl%0d_flush_cnt", i), int'(fc_a), tbl[i].fc);
    end

    // Timeout on dut_b (TIMEOUT=4): HALT is sticky until reset.
    b_to_run();
    drive(rst_v, mk(0, 0, 0, 0, 0, 0, 0, 0));
    chk("b_run", int'(o_b), 6'b100000);
    b_miss_check("b_timeout");
    for (int k = 0; k < 3; k++) begin
      drive(rst_v, mk(1, 0, 0, 0, 0, 0, 1, 1));
      chk("b_halt_sticky", int'(o_b), 6'b010011);
    end
    drive(rst_v, rst_v);
    chk("b_halt_in_rst_cycle", int'(o_b), 6'b010011);
    drive(rst_v, mk(0, 0, 0, 0, 0, 0, 0, 0));
    chk("b_reset_exit", int'(o_b), 6'b001100);
    chk("b_reset_stall_cnt", int'(sc_b), 0);
    chk("b_reset_flush_cnt", int'(fc_b), 0);

    // Reset mid-wait must discard the partial wait count.
    b_to_run();
    drive(rst_v, mk(0, 0, 0, 0, 0, 0, 1, 0));
    drive(rst_v, mk(0, 0, 0, 0, 0, 0, 1, 0));
    drive(rst_v, mk(0, 0, 0, 0, 0, 0, 1, 0));
    b_to_run();
    drive(rst_v, mk(0, 0, 0, 0, 0, 0, 0, 0));
    chk("b_run_after_midwait_rst", int'(o_b), 6'b100000);
    b_miss_check("b_timeout2");

    // Stall counter saturation with CNT_W=4.
    b_to_run();
    for (int k = 0; k < 20; k++) begin
      drive(rst_v, mk(0, 5, 0, 1, 5, 0, 0, 0));
      chk("b_sat_ctrl", int'(o_b), 6'b010100);
      chk("b_sat_cnt", int'(sc_b), (k < 15) ? k : 15);
    end
    drive(rst_v, mk(0, 0, 0, 0, 0, 0, 0, 0));
    chk("b_sat_final", int'(sc_b), 15);

    // Randomized traffic against the model on both instances.
    for (int i = 0; i < 3000; i++) begin
      x.rst     = ($urandom_range(0, 99) != 0);
      x.start   = ($urandom_range(0, 3) == 0);
      x.rs1     = 5'($urandom_range(0, 7));
      x.rs2     = 5'($urandom_range(0, 7));
      x.memread = ($urandom_range(0, 2) == 0);
      x.rd      = 5'($urandom_range(0, 7));
      x.br      = ($urandom_range(0, 3) == 0);
      x.req     = ($urandom_range(0, 2) == 0);
      x.ack     = ($urandom_range(0, 2) == 0);
      drive(x, x);
      chk("rnd_a_ctrl", int'(o_a), int'(mdl_out(mdl_a.mode, x)));
      chk("rnd_a_stall_cnt", int'(sc_a), mdl_a.stall);
      chk("rnd_a_flush_cnt", int'(fc_a), mdl_a.flush);
      chk("rnd_a_state", int'(st_a), mode_state(mdl_a.mode));
      chk("rnd_b_ctrl", int'(o_b), int'(mdl_out(mdl_b.mode, x)));
      chk("rnd_b_stall_cnt", int'(sc_b), mdl_b.stall);
      chk("rnd_b_flush_cnt", int'(fc_b), mdl_b.flush);
      chk("rnd_b_state", int'(st_b), mode_state(mdl_b.mode));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and sequencing controller for the 5-stage RISC-V pipeline. Generates the PC-write enable, the stall/flush controls for the IF/ID register, the bubble control for ID/EX and a whole-pipe freeze for data-memory misses. Holds the pipeline in an idle state until started and halts it on a memory timeout. Keeps saturating stall and flush counters for performance reporting.

## Interface
Parameters:
- TIMEOUT, 64: maximum MEM_WAIT cycles before halting; range 1..255.
- CNT_W, 16: width of the performance counters.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-low reset.
- start_i  in  1  leave IDLE; level-sampled.
- id_rs1_i  in  5  rs1 address of the instruction in ID.
- id_rs2_i  in  5  rs2 address of the instruction in ID.
- ex_memread_i  in  1  instruction in EX is a load.
- ex_rd_i  in  5  destination register of the instruction in EX.
- branch_taken_i  in  1  branch resolved taken in ID this cycle.
- mem_req_i  in  1  MEM stage issues a data-memory access this cycle.
- mem_ack_i  in  1  data memory completes the access this cycle.
- pc_write_o  out  1  PC may update.
- if_id_stall_o  out  1  IF/ID holds its contents.
- if_id_flush_o  out  1  IF/ID loads a NOP (instr = 0).
- id_ex_flush_o  out  1  ID/EX loads a bubble.
- pipe_freeze_o  out  1  ID/EX, EX/MEM and MEM/WB hold.
- halted_o  out  1  controller is in HALT.
- stall_cnt_o  out  CNT_W  cycles with pc_write_o = 0 in RUN or MEM_WAIT.
- flush_cnt_o  out  CNT_W  cycles with if_id_flush_o = 1 in RUN.

## Operation
FSM states: IDLE, RUN, MEM_WAIT, HALT.
- IDLE: pc_write_o = 0; if_id_flush_o = 1; id_ex_flush_o = 1; all other controls 0. start_i = 1 moves the FSM to RUN.
- RUN: controls are combinational (Mealy) from inputs, in strict priority order:
  1. Miss: mem_req_i = 1 and mem_ack_i = 0. Sets pc_write_o = 0, if_id_stall_o = 1, pipe_freeze_o = 1; all flushes 0. The FSM moves to MEM_WAIT.
  2. Load-use: ex_memread_i = 1, ex_rd_i ≠ 0, and ex_rd_i equals id_rs1_i or id_rs2_i. Sets pc_write_o = 0, if_id_stall_o = 1, id_ex_flush_o = 1. branch_taken_i is ignored, because the operands are not yet valid.
  3. Branch: branch_taken_i = 1. Sets pc_write_o = 1 and if_id_flush_o = 1.
  4. Otherwise: pc_write_o = 1 and all other controls 0.
- MEM_WAIT: same outputs as RUN case 1, whatever the other inputs are.
  - mem_ack_i = 1 returns the FSM to RUN at the next edge. The freeze is still asserted in the ack cycle.
  - A wait counter is cleared on entry and increments every MEM_WAIT cycle without an ack.
  - If the count reaches TIMEOUT with no ack, the FSM moves to HALT.
- HALT: pc_write_o = 0; if_id_stall_o = 1; pipe_freeze_o = 1; halted_o = 1. Only rst_i exits HALT.
- Counters:
  - Saturate at all-ones; they never wrap.
  - Both increment on the same edge as the qualifying cycle.
  - They are not cleared by state transitions, only by reset.
- if_id_stall_o and if_id_flush_o are never both 1 in any state.

## Timing
- Reset (rst_i = 0 at an edge): state = IDLE, wait counter = 0, stall_cnt_o = 0, flush_cnt_o = 0. Outputs then show the IDLE values: pc_write_o = 0, if_id_stall_o = 0, if_id_flush_o = 1, id_ex_flush_o = 1, pipe_freeze_o = 0, halted_o = 0.
- Reset takes effect from any state, including mid MEM_WAIT; the pending wait count is discarded.
- Hazard controls have 0-cycle latency: they are valid in the same cycle as the causing inputs.
- IDLE→RUN: the first cycle after the start_i edge is a RUN cycle.
- A hit (mem_req_i and mem_ack_i in the same RUN cycle) causes no freeze and no state change.
- Miss of N cycles, where the ack arrives in the Nth MEM_WAIT cycle: freeze lasts N+1 cycles (the request cycle plus N wait cycles), then RUN.
- Timeout: with no ack ever, HALT is entered TIMEOUT+1 cycles after the request cycle.
- A load-use stall lasts exactly 1 cycle. In the next cycle the bubble sits in EX, so the condition clears naturally.

## Structure
- Shared package `hazard_pkg`: state enum (IDLE, RUN, MEM_WAIT, HALT), constant REG_ZERO = 5'd0, NOP instruction constant 32'h0.
- One sub-module, `sat_counter` (parameter W; ports clk_i, rst_i, inc_i, cnt_o). It is instantiated twice, once per performance counter.
- Wait counter and FSM are inline.

## Test plan
- Reset, then start_i pulse: IDLE outputs hold until start. pc_write_o rises to 1 in the first RUN cycle; both counters read 0.
- ex_memread_i = 1, ex_rd_i = 5, id_rs2_i = 5, branch_taken_i = 1 → pc_write_o = 0, if_id_stall_o = 1, id_ex_flush_o = 1, if_id_flush_o = 0 for 1 cycle. Repeat with ex_rd_i = 0 → no stall.
- branch_taken_i = 1 alone → if_id_flush_o = 1, pc_write_o = 1; flush_cnt_o increments by 1.
- mem_req_i at cycle t, mem_ack_i at t+3 → pipe_freeze_o high at t..t+3, RUN again at t+4; stall_cnt_o += 4.
- TIMEOUT = 4, mem_req_i with no ack → halted_o = 1 from cycle t+5. It stays 1 through start_i and mem_ack_i and clears only on rst_i.
- Preload the counter near all-ones (CNT_W = 4) and stall 20 cycles → stall_cnt_o saturates at 4'hF.
